// File: rtl/dnn_0117.sv
// Four-neuron fixed-weight frame classifier: accumulate N_IN samples, then ReLU/shift/saturate and argmax.
// Optional bias per neuron is enabled by defining DNN_0117_BIAS_EN.
module dnn_0117 #(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SHIFT = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] vec_in,
   input  logic        dv_in,
   output logic [10:0] vec_out,
   output logic        dv_out
);
   localparam int unsigned   KW     = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);

   logic [KW-1:0]      k_q;
   logic signed [22:0] acc_q [N_OUT];
   logic signed [22:0] acc_d [N_OUT];
   logic signed [22:0] sum_q [N_OUT];
   logic [8:0]         score_q [N_OUT];
   logic [8:0]         score_d [N_OUT];
   logic               v1_q, v2_q, dv_out_q;
   logic [10:0]        vec_out_q;
   logic signed [22:0] x_ext;
   logic [1:0]         k_lo, k_neg;
   logic [1:0]         idx;
   logic               last;

   assign x_ext = {{3{vec_in[19]}}, vec_in};
   assign k_lo  = 2'(k_q);
   assign k_neg = k_lo + 2'd2;
   assign last  = dv_in && (k_q == K_LAST);

   // Weight +1 where k mod 4 == n, -1 where (k+2) mod 4 == n.
   always_comb begin
      for (int unsigned n = 0; n < N_OUT; n++) begin
         acc_d[n] = acc_q[n];
         if (dv_in) begin
            if (k_lo == 2'(n))       acc_d[n] = acc_q[n] + x_ext;
            else if (k_neg == 2'(n)) acc_d[n] = acc_q[n] - x_ext;
         end
      end
   end

   always_comb begin : g_score
      logic [23:0] biased;
      logic [23:0] shifted;
      for (int unsigned n = 0; n < N_OUT; n++) begin
         biased = {sum_q[n][22], sum_q[n]};
`ifdef DNN_0117_BIAS_EN
         biased = biased + 24'(n << SHIFT);
`endif
         shifted    = biased >> SHIFT;
         score_d[n] = '0;
         if (!biased[23]) begin
            if (shifted > 24'd511) score_d[n] = '1;
            else                   score_d[n] = shifted[8:0];
         end
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      idx = '0;
      for (int unsigned n = 1; n < N_OUT; n++) begin
         if (score_q[n] > score_q[idx]) idx = 2'(n);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q       <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         dv_out_q  <= 1'b0;
         vec_out_q <= '0;
         for (int unsigned n = 0; n < N_OUT; n++) begin
            acc_q[n]   <= '0;
            sum_q[n]   <= '0;
            score_q[n] <= '0;
         end
      end else begin
         v1_q     <= last;
         v2_q     <= v1_q;
         dv_out_q <= v2_q;
         if (dv_in) k_q <= last ? '0 : k_q + KW'(1);
         for (int unsigned n = 0; n < N_OUT; n++) begin
            acc_q[n] <= last ? '0 : acc_d[n];
            if (last) sum_q[n]   <= acc_d[n];
            if (v1_q) score_q[n] <= score_d[n];
         end
         if (v2_q) vec_out_q <= {idx, score_q[idx]};
      end
   end

   assign vec_out = vec_out_q;
   assign dv_out  = dv_out_q;

endmodule

// File: tb/tb_dnn_0117.sv
// Bench for dnn_0117: directed frames from the requirements plus random frames checked against a sum/argmax model.
module tb_dnn_0117;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] vec_in = '0;
   logic        dv_in = 1'b0;
   logic [10:0] vec_out;
   logic        dv_out;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int last_edge = 0;
   logic [10:0] pv[$];
   int          pc[$];

   dnn_0117 #(.N_IN(8), .N_OUT(4), .SHIFT(12)) dut (
      .clk(clk), .reset(reset), .vec_in(vec_in), .dv_in(dv_in),
      .vec_out(vec_out), .dv_out(dv_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (dv_out) begin
      pv.push_back(vec_out);
      pc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // gap < 0 selects a random 0..3 idle cycles after each sample.
   task automatic send_frame(input int xs[8], input int gap);
      int g;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         vec_in = 20'(xs[k]);
         dv_in = 1'b1;
         last_edge = cyc + 1;
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin
            @(negedge clk);
            dv_in = 1'b0;
            vec_in = 20'($urandom);
         end
      end
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         @(negedge clk);
         dv_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      dv_in = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic expect_one(input string tag, input logic [10:0] exp);
      drain(6);
      chk({tag, "_count"}, 32'(pv.size()), 32'd1);
      if (pv.size() >= 1) begin
         chk({tag, "_vec"}, 32'(pv[0]), 32'(exp));
         chk({tag, "_lat"}, 32'(pc[0]), 32'(last_edge + 2));
      end
      chk({tag, "_hold"}, 32'(vec_out), 32'(exp));
      pv.delete();
      pc.delete();
   endtask

   function automatic logic [10:0] model(input int xs[8]);
      longint s;
      int sc[4];
      int best;
      for (int n = 0; n < 4; n++) begin
         s = 0;
         for (int k = 0; k < 8; k++) begin
            if (k % 4 == n) s += xs[k];
            else if ((k + 2) % 4 == n) s -= xs[k];
         end
`ifdef DNN_0117_BIAS_EN
         s += longint'(n) * 4096;
`endif
         if (s < 0) sc[n] = 0;
         else if (s / 4096 > 511) sc[n] = 511;
         else sc[n] = int'(s / 4096);
      end
      best = 0;
      for (int n = 1; n < 4; n++) if (sc[n] > sc[best]) best = n;
      return {2'(best), 9'(sc[best])};
   endfunction

   int f1[8]   = '{40960, 0, 0, 0, 0, 0, 0, 0};
   int f2[8]   = '{0, 524287, 0, -524288, 0, 524287, 0, -524288};
   int fz[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
   int ft[8]   = '{8192, 8192, 0, 0, 0, 0, 0, 0};
   int fr[8];
   int first_pulse;

   initial begin
      drain(2);
      chk("reset_dv_out", 32'(dv_out), 32'd0);
      chk("reset_vec_out", 32'(vec_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drain(2);

      send_frame(f1, 0);
      expect_one("frame1", 11'h00A);

      send_frame(f2, 0);
      expect_one("frame2", 11'h3FF);

      send_frame(fz, 0);
`ifdef DNN_0117_BIAS_EN
      expect_one("zero", 11'h603);
`else
      expect_one("zero", 11'h000);
`endif

      send_frame(ft, 0);
`ifdef DNN_0117_BIAS_EN
      expect_one("tie", 11'h203);
`else
      expect_one("tie", 11'h002);
`endif

      // Partial frame discarded by a one-cycle reset.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vec_in = 20'd12345;
         dv_in = 1'b1;
      end
      do_reset();
      send_frame(f1, 0);
      expect_one("midreset", 11'h00A);

      send_frame(f1, 20);
      expect_one("gap21", 11'h00A);

      // Reset while the result is in the E+1 and E+2 stages.
      send_frame(f1, 0);
      do_reset();
      drain(6);
      chk("cancel_e1_count", 32'(pv.size()), 32'd0);
      chk("cancel_e1_vec", 32'(vec_out), 32'd0);
      pv.delete(); pc.delete();
      send_frame(f2, 0);
      drain(1);
      do_reset();
      drain(6);
      chk("cancel_e2_count", 32'(pv.size()), 32'd0);
      pv.delete(); pc.delete();

      send_frame(f1, 0);
      send_frame(f2, 0);
      drain(8);
      chk("b2b_count", 32'(pv.size()), 32'd2);
      if (pv.size() == 2) begin
         chk("b2b_vec0", 32'(pv[0]), 32'h00A);
         chk("b2b_vec1", 32'(pv[1]), 32'h3FF);
         first_pulse = pc[0];
         chk("b2b_spacing", 32'(pc[1] - first_pulse), 32'd8);
         chk("b2b_lat", 32'(pc[1]), 32'(last_edge + 2));
      end
      pv.delete(); pc.delete();

      for (int f = 0; f < 12; f++) begin
         for (int k = 0; k < 8; k++) begin
            if (f % 2 == 0) fr[k] = int'($urandom_range(0, 1048575)) - 524288;
            else            fr[k] = int'($urandom_range(0, 32767)) - 16384;
         end
         send_frame(fr, -1);
         expect_one($sformatf("rand%0d", f), model(fr));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dnn_0117.md
DNN_0117 -- requirements
Module: dnn_0117

Interface
REQ-001 Parameter N_IN, default 8, number of input samples per frame.
REQ-002 Parameter N_OUT, default 4, number of neurons (fixed at 4; the vec_out index field is 2 bits).
REQ-003 Parameter SHIFT, default 12, right-shift applied to a neuron sum to form its score.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vec_in  input  20  signed two's-complement feature sample, valid when dv_in=1.
REQ-007 dv_in  input  1  one-cycle strobe; each high cycle delivers one sample; arbitrary gaps allowed.
REQ-008 vec_out  output  11  result {idx[1:0], score[8:0]}; holds its value until the next result.
REQ-009 dv_out  output  1  one-cycle pulse marking a new vec_out.

Function
REQ-010 A sample counter k (0..N_IN-1) indexes the accepted samples x[k] of the current frame.
REQ-011 Fixed weights W[n][k]:
- W[n][k] = +1 if (k mod 4) == n.
- W[n][k] = -1 if ((k+2) mod 4) == n.
- W[n][k] = 0 otherwise.
REQ-012 Four signed 23-bit accumulators acc[n] each add W[n][k]*x[k] at the edge sampling dv_in=1; the sum never overflows.
REQ-013 The edge accepting sample k=N_IN-1 (edge E) snapshots the final sums into result registers, clears every acc[n] to 0, and resets k to 0.
REQ-014 A sample arriving at E+1 or later starts the next frame without loss; the output pipeline never stalls input.
REQ-015 Edge E+1 registers, per neuron, score[n] = min(511, max(0, sum[n]) >> SHIFT): ReLU, logical shift, unsigned 9-bit saturation.
REQ-016 Edge E+2 registers idx = argmax score[n]; ties resolve to the lowest index; all-zero scores give idx=0.
REQ-017 Edge E+2 also registers vec_out = {idx, score[idx]} and asserts dv_out for exactly one cycle.
REQ-018 Latency: dv_out is high in the cycle following edge E+2, two edges after the edge that sampled the last dv_in of the frame.
REQ-019 Frames complete at least N_IN cycles apart, so the output pipeline never holds two frames at once.

Reset
REQ-020 While reset=1 at a rising edge:
- k, every acc[n], every result and score register, vec_out and dv_out clear to 0.
- dv_in is ignored.
REQ-021 A reset mid-frame discards the partial frame; the next accepted sample is k=0.
REQ-022 A reset during the E+1 or E+2 pipeline cancels the pending result; no dv_out is produced for that frame.

Configuration
REQ-023 Macro DNN_0117_BIAS_EN:
- Defined: bias B[n] = n << SHIFT (0, 4096, 8192, 12288 at the default SHIFT) is added to sum[n] before ReLU.
- Undefined: no bias logic exists and the score is computed from sum[n] alone.

Verification
REQ-024 The bench shall cover these directed scenarios.
- Frame x=[40960,0,0,0,0,0,0,0] -> sums n0=40960, n2=-40960; vec_out=0x00A (idx 0, score 10); dv_out pulses once, 2 cycles after the 8th dv_in.
- Frame x=[0,524287,0,-524288,0,524287,0,-524288] -> sum n1=2097150; vec_out=0x3FF (idx 1, score 511).
- All-zero frame -> vec_out=0x000 with a dv_out pulse; with DNN_0117_BIAS_EN -> vec_out=0x603 (idx 3, score 3).
- Tie frame x=[8192,8192,0,0,0,0,0,0] -> n0=n1=8192 (n2,n3 negative); vec_out=0x002 (idx 0, tie picks lowest).
- Mid-frame reset: 3 samples, reset 1 cycle, then the first scenario's frame -> only one dv_out, vec_out=0x00A; the first scenario repeated with dv_in every 21 cycles (210 ns at a 10 ns clock) gives an identical result.
- Back-to-back: 16 consecutive dv_in cycles (first two scenarios' frames) -> two dv_out pulses 8 cycles apart, 0x00A then 0x3FF.
